// File: rtl/imuldiv_int_div_iterative.sv
// Iterative restoring divider, one quotient bit per cycle, val/rdy in and out.
// Optional IMULDIV_DIV_FASTPATH_EN: divide-by-zero and zero-dividend requests skip CALC/SIGN.
module imuldiv_int_div_iterative #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           divreq_msg_fn,
  input  logic [W-1:0]   divreq_msg_a,
  input  logic [W-1:0]   divreq_msg_b,
  input  logic           divreq_val,
  output logic           divreq_rdy,
  output logic [2*W-1:0] divresp_msg_result,
  output logic           divresp_val,
  input  logic           divresp_rdy
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  counter;
  logic           sa, sb, dbz;
  logic [2*W-1:0] remquo;
  logic [W-1:0]   b_mag;

  logic           a_neg, b_neg, b_zero;
  logic [W-1:0]   a_mag_in, b_mag_in;
  logic [2*W-1:0] shifted;
  logic [W:0]     diff;
  logic [W-1:0]   rem_fix, quo_fix;

  always_comb begin
    a_neg    = divreq_msg_fn & divreq_msg_a[W-1];
    b_neg    = divreq_msg_fn & divreq_msg_b[W-1];
    b_zero   = (divreq_msg_b == '0);
    a_mag_in = a_neg ? -divreq_msg_a : divreq_msg_a;
    b_mag_in = b_neg ? -divreq_msg_b : divreq_msg_b;
    shifted  = {remquo[2*W-2:0], 1'b0};
    diff     = {1'b0, shifted[2*W-1:W]} - {1'b0, b_mag};
    rem_fix  = sa ? -remquo[2*W-1:W] : remquo[2*W-1:W];
    quo_fix  = (sa ^ sb) ? -remquo[W-1:0] : remquo[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      counter            <= '0;
      sa                 <= 1'b0;
      sb                 <= 1'b0;
      dbz                <= 1'b0;
      remquo             <= '0;
      b_mag              <= '0;
      divreq_rdy         <= 1'b1;
      divresp_val        <= 1'b0;
      divresp_msg_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (divreq_val) begin
            sa         <= a_neg;
            sb         <= b_neg;
            dbz        <= b_zero;
            b_mag      <= b_mag_in;
            counter    <= CW'(W);
            divreq_rdy <= 1'b0;
            // With a zero divisor every step subtracts nothing, so seeding the raw
            // dividend bits leaves quotient=all ones and remainder=raw dividend.
            remquo     <= {{W{1'b0}}, (b_zero ? divreq_msg_a : a_mag_in)};
            state      <= CALC;
`ifdef IMULDIV_DIV_FASTPATH_EN
            if (b_zero || (divreq_msg_a == '0)) begin
              remquo <= b_zero ? {divreq_msg_a, {W{1'b1}}} : '0;
              state  <= DONE;
            end
`endif
          end
        end
        CALC: begin
          if (!diff[W]) remquo <= {diff[W-1:0], shifted[W-1:1], 1'b1};
          else          remquo <= shifted;
          counter <= counter - 1'b1;
          if (counter == CW'(1)) state <= SIGN;
        end
        SIGN: begin
          if (!dbz) remquo <= {rem_fix, quo_fix};
          state <= DONE;
        end
        DONE: begin
          // First DONE cycle loads the output register; the response is offered from then on.
          if (!divresp_val) begin
            divresp_val        <= 1'b1;
            divresp_msg_result <= remquo;
          end else if (divresp_rdy) begin
            divresp_val <= 1'b0;
            divreq_rdy  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imuldiv_int_div_iterative.sv
// Self-checking bench for imuldiv_int_div_iterative: directed table, corner sequences, random vs. arithmetic model.
module tb_imuldiv_int_div_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a, divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val;
  logic        divresp_rdy;

  int checks = 0;
  int failures = 0;

  imuldiv_int_div_iterative #(.W(32)) dut (
    .clk(clk), .rst(rst),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
    .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic logic [63:0] model(input logic fn, input logic [31:0] a, input logic [31:0] b);
    longint sx, sy, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!fn) return {a % b, a / b};
    sx = longint'($signed(a));
    sy = longint'($signed(b));
    q  = sx / sy;
    r  = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int lat_exp(input logic [31:0] a, input logic [31:0] b);
`ifdef IMULDIV_DIV_FASTPATH_EN
    return (a == 32'd0 || b == 32'd0) ? 1 : 34;
`else
    return (a == b) ? 34 : 34;
`endif
  endfunction

  // Issue one request and collect its response; called #1 after a clock edge.
  task automatic run(input logic fn, input logic [31:0] a, input logic [31:0] b, input logic early_rdy,
                     output logic [63:0] res, output int lat, output logic busy_ok);
    int guard = 0;
    while (!divreq_rdy && guard < 100) begin @(posedge clk); #1; guard++; end
    divreq_msg_fn = fn; divreq_msg_a = a; divreq_msg_b = b; divreq_val = 1'b1;
    @(posedge clk); #1;
    lat = 0; busy_ok = 1'b1;
    divresp_rdy = early_rdy;
    while (!divresp_val && lat < 200) begin
      if (divreq_rdy) busy_ok = 1'b0;
      divreq_val    = 1'($urandom_range(0, 1));
      divreq_msg_fn = 1'($urandom_range(0, 1));
      divreq_msg_a  = $urandom;
      divreq_msg_b  = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    divreq_val  = 1'b0;
    res         = divresp_msg_result;
    divresp_rdy = 1'b1;
    @(posedge clk); #1;
    divresp_rdy = 1'b0;
  endtask

  initial begin
    logic [63:0] res, held;
    int          lat;
    logic        busy_ok, stable;

    tbl[0] = '{1'b0, 32'd100,        32'd7,        {32'd2, 32'd14}};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,{32'h0000_0001, 32'hFFFF_FFFD}};
    tbl[3] = '{1'b0, 32'd5,          32'd0,        {32'h0000_0005, 32'hFFFF_FFFF}};
    tbl[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,{32'h0000_0000, 32'h8000_0000}};
    tbl[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        {32'h0000_0000, 32'hFFFF_FFFF}};
    tbl[6] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        {32'hFFFF_FFFB, 32'hFFFF_FFFF}};
    tbl[7] = '{1'b0, 32'd0,          32'd7,        {32'd0, 32'd0}};
    tbl[8] = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0001,{32'h7FFF_FFFE, 32'd1}};
    tbl[9] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,{32'hFFFF_FFFE, 32'd14}};

    rst = 1'b1; divreq_val = 1'b0; divreq_msg_fn = 1'b0; divreq_msg_a = '0; divreq_msg_b = '0; divresp_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", 64'(divreq_rdy), 64'd1);
    chk("reset_val", 64'(divresp_val), 64'd0);
    chk("reset_result", divresp_msg_result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run(tbl[i].fn, tbl[i].a, tbl[i].b, 1'b0, res, lat, busy_ok);
      chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(lat_exp(tbl[i].a, tbl[i].b)));
      chk($sformatf("vec%0d_busy_rdy", i), 64'(busy_ok), 64'd1);
    end

    // Back-pressure: response held 10 cycles, then released.
    divreq_msg_fn = 1'b0; divreq_msg_a = 32'd100; divreq_msg_b = 32'd7; divreq_val = 1'b1;
    @(posedge clk); #1;
    divreq_val = 1'b0;
    lat = 0;
    while (!divresp_val && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", 64'(lat), 64'd34);
    held = divresp_msg_result;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      divresp_rdy = 1'b0;
      @(posedge clk); #1;
      if (!divresp_val || divreq_rdy || divresp_msg_result !== held) stable = 1'b0;
    end
    chk("bp_held", 64'(stable), 64'd1);
    chk("bp_result", held, {32'd2, 32'd14});
    divresp_rdy = 1'b1;
    @(posedge clk); #1;
    divresp_rdy = 1'b0;
    chk("bp_release_val", 64'(divresp_val), 64'd0);
    chk("bp_release_rdy", 64'(divreq_rdy), 64'd1);

    // Reset in the middle of CALC.
    divreq_msg_fn = 1'b0; divreq_msg_a = 32'd1000000; divreq_msg_b = 32'd3; divreq_val = 1'b1;
    @(posedge clk); #1;
    divreq_val = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_val", 64'(divresp_val), 64'd0);
    chk("midrst_rdy", 64'(divreq_rdy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    run(1'b0, 32'd9, 32'd3, 1'b0, res, lat, busy_ok);
    chk("after_rst_result", res, {32'd0, 32'd3});
    chk("after_rst_latency", 64'(lat), 64'd34);

    // Random traffic against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic        fn;
      logic [31:0] a, b;
      fn = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = -$urandom_range(0, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'd0;
      run(fn, a, b, 1'($urandom_range(0, 1)), res, lat, busy_ok);
      chk($sformatf("rnd%0d_result fn=%0d a=%h b=%h", i, fn, a, b), res, model(fn, a, b));
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(lat_exp(a, b)));
      chk($sformatf("rnd%0d_busy_rdy", i), 64'(busy_ok), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
